// File: rtl/sel_demux_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sel_pkg
//  Description : Shared types and helpers for the sel_demux_pkt packet
//                demultiplexer: FSM state encoding, default parameters and
//                a constant-evaluable clog2.
//  Revision    : 1.0  initial release
// ============================================================================
package sel_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_N  = 3;
    localparam int DEF_SW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    // Bits needed to index v items (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sel_demux_pkt_if.sv
`default_nettype none
// ============================================================================
//  Module      : sel_demux_pkt_if
//  Description : Stream bundle for the packet demultiplexer.
//                Source side : in_data, in_valid, in_last, in_ready, sel
//                Sink side   : out_data, out_last, out_valid[N], out_ready[N]
//                Status      : busy, drop (drop only with SEL_DEMUX_DROP_EN)
//                modport slave  - the demultiplexer
//                modport master - the environment driving/consuming it
//  Revision    : 1.0  initial release
// ============================================================================
interface sel_demux_pkt_if
    import sel_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N,
    parameter int SW = DEF_SW
) ();

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [SW-1:0] sel;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic          busy;
`ifdef SEL_DEMUX_DROP_EN
    logic          drop;
`endif

    modport slave (
        input  in_data, in_valid, in_last, sel, out_ready,
        output in_ready, out_data, out_last, out_valid, busy
`ifdef SEL_DEMUX_DROP_EN
        , output drop
`endif
    );

    modport master (
        output in_data, in_valid, in_last, sel, out_ready,
        input  in_ready, out_data, out_last, out_valid, busy
`ifdef SEL_DEMUX_DROP_EN
        , input drop
`endif
    );

endinterface
`default_nettype wire

// File: rtl/sel_demux_pkt_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sel_out_reg
//  Description : Single-entry valid/ready holding register with a one-hot
//                valid per destination and a registered destination index.
//                i_load  - capture i_data/i_last for destination i_dest
//                i_ready - per-destination ready from the consumers
//                o_full  - a beat is held
//                o_drain - the held beat is taken this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module sel_out_reg
    import sel_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N,
    parameter int SW = DEF_SW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_load,
    input  wire logic [DW-1:0] i_data,
    input  wire logic          i_last,
    input  wire logic [SW-1:0] i_dest,
    input  wire logic [N-1:0]  i_ready,
    output      logic          o_full,
    output      logic          o_drain,
    output      logic [N-1:0]  o_valid,
    output      logic [DW-1:0] o_data,
    output      logic          o_last
);

    localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);

    logic [N-1:0]  r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;
    logic [IW-1:0] r_dest;
    logic [N-1:0]  w_onehot;
    logic          w_full;
    logic          w_drain;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N; i++) begin
            w_onehot[i] = (i_dest == SW'(i));
        end
    end

    assign w_full  = |r_valid;
    // Only the consumer of the held beat can release it.
    assign w_drain = w_full & i_ready[r_dest];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_dest  <= '0;
        end else if (i_load) begin
            r_valid <= w_onehot;
            r_data  <= i_data;
            r_last  <= i_last;
            r_dest  <= i_dest[IW-1:0];
        end else if (w_drain) begin
            r_valid <= '0;
        end
    end

    assign o_full  = w_full;
    assign o_drain = w_drain;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/sel_demux_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : sel_demux_pkt
//  Description : Registered 1-to-N packet demultiplexer. The destination is
//                sampled from sel on the first beat of a packet and held
//                until the last beat. One register stage, full throughput.
//                Ports: clk, rst_n (async active-low), bus (slave modport
//                of sel_demux_pkt_if).
//                Optional macro SEL_DEMUX_DROP_EN: packets whose first-beat
//                sel >= N are swallowed and signalled with a drop pulse;
//                without it such packets go to destination N-1.
//  Revision    : 1.0  initial release
// ============================================================================
module sel_demux_pkt
    import sel_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N,
    parameter int SW = DEF_SW
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sel_demux_pkt_if.slave    bus
);

    state_t        r_state;
    logic [SW-1:0] r_dest;
    logic          r_busy;
    logic          w_sel_oob;
    logic [SW-1:0] w_sel_map;
    logic [SW-1:0] w_dest_cur;
    logic          w_dropping;
    logic          w_full;
    logic          w_drain;
    logic          w_in_ready;
    logic          w_acc;
    logic          w_load;
    logic [N-1:0]  w_out_valid;
    logic [DW-1:0] w_out_data;
    logic          w_out_last;

    assign w_sel_oob = (int'(bus.sel) >= N);

`ifdef SEL_DEMUX_DROP_EN
    logic r_drop;
    assign w_sel_map  = bus.sel;
    // Beats of a dropped packet never touch the holding register.
    assign w_dropping = (r_state == DROP) | ((r_state == IDLE) & w_sel_oob);
`else
    assign w_sel_map  = w_sel_oob ? SW'(N - 1) : bus.sel;
    assign w_dropping = 1'b0;
`endif

    assign w_dest_cur = (r_state == IDLE) ? w_sel_map : r_dest;
    // Ready depends on the held beat's consumer, never on in_valid.
    assign w_in_ready = w_dropping | ~w_full | w_drain;
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_load     = w_acc & ~w_dropping;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dest  <= '0;
            r_busy  <= 1'b0;
`ifdef SEL_DEMUX_DROP_EN
            r_drop  <= 1'b0;
`endif
        end else begin
`ifdef SEL_DEMUX_DROP_EN
            r_drop <= w_acc & w_dropping & bus.in_last;
`endif
            if (w_acc) begin
                case (r_state)
                    IDLE: begin
                        r_dest <= w_sel_map;
                        if (!bus.in_last) begin
`ifdef SEL_DEMUX_DROP_EN
                            r_state <= w_sel_oob ? DROP : ROUTE;
`else
                            r_state <= ROUTE;
`endif
                            r_busy  <= 1'b1;
                        end
                    end
                    default: begin
                        if (bus.in_last) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    sel_out_reg #(
        .DW (DW),
        .N  (N),
        .SW (SW)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (bus.in_data),
        .i_last  (bus.in_last),
        .i_dest  (w_dest_cur),
        .i_ready (bus.out_ready),
        .o_full  (w_full),
        .o_drain (w_drain),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_last  (w_out_last)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = r_busy;
`ifdef SEL_DEMUX_DROP_EN
    assign bus.drop      = r_drop;
`endif

endmodule
`default_nettype wire

// File: doc/sel_demux_pkt.md
Name: sel_demux_pkt

Overview:
- Registered 1-to-N packet demultiplexer; the receive-side counterpart of the 2:1 / N:1 selectors.
- Routes a valid/ready stream with packet boundaries (IN_LAST) to one of N destinations.
- Destination is sampled from SEL on the first beat of each packet and held until the last beat.
- Sits between a shared source bus and per-destination consumers.

Parameters:
- DW, 8, data width in bits.
- N, 3, number of destinations, 2..2**SW.
- SW, 2, SEL width; must satisfy 2**SW >= N.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  DW  source data.
- IN_VALID  input  1  source beat valid.
- IN_LAST  input  1  marks the final beat of a packet.
- IN_READY  output  1  block can accept a beat.
- SEL  input  SW  destination index; sampled only on the first beat of a packet.
- OUT_DATA  output  DW  registered data, shared by all destinations.
- OUT_LAST  output  1  registered last flag, shared.
- OUT_VALID  output  N  one-hot valid, at most one bit set.
- OUT_READY  input  N  per-destination ready.
- BUSY  output  1  high while in ROUTE state (mid-packet).

Behaviour:
- Reset (async, RST_N=0):
  - OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, BUSY=0; state=IDLE; dest register=0.
  - IN_READY is combinational and equals 1 after reset.
- Output stage:
  - One register stage; latency is 1 cycle from input acceptance to OUT_VALID.
  - Holding register is full when |OUT_VALID.
  - IN_READY = ~full | OUT_READY[dest_cur]. There is no combinational path from IN_VALID to IN_READY.
  - A beat is accepted on IN_VALID & IN_READY at a rising edge. OUT_DATA and OUT_LAST load, and OUT_VALID[dest_cur] is set.
  - If a beat is not accepted and OUT_READY[dest_cur] is high, OUT_VALID clears.
  - OUT_DATA, OUT_LAST and OUT_VALID stay stable while a valid is pending and its ready is low.
- dest_cur:
  - Equals SEL in IDLE; equals the latched dest register in ROUTE.
  - The ready term uses the destination of the beat currently held in the register.
  - A new packet to a different destination waits until the held beat drains.
  - Full throughput (one beat per cycle) is required when the consumer is always ready, including back-to-back packets to different destinations.
- FSM:
  - IDLE: on first-beat acceptance, latch dest=SEL. If IN_LAST=1 (single-beat packet), stay in IDLE; otherwise go to ROUTE.
  - ROUTE: SEL is ignored. Beats go to the latched dest. Acceptance with IN_LAST=1 returns to IDLE.
  - BUSY=1 exactly in ROUTE.
- Out-of-range SEL (SEL >= N) is handled per the Optional Feature.
- A deasserted OUT_READY on a non-selected destination has no effect.
- Reset asserted mid-packet:
  - Immediately clears state and outputs.
  - The partial packet is abandoned; the next accepted beat is treated as a first beat.

Optional Feature:
- Macro: SEL_DEMUX_DROP_EN.
- Defined:
  - A packet whose first-beat SEL >= N is accepted at full rate (IN_READY=1 for its beats) and discarded; no OUT_VALID is raised.
  - Output DROP (1 bit, reset 0) pulses high for one cycle on acceptance of that packet's last beat.
  - The FSM uses a DROP state in place of ROUTE; BUSY=1 in DROP.
- Not defined:
  - SEL >= N maps to destination N-1.
  - No DROP port exists.

Decomposition:
- Package sel_pkg holds:
  - state typedef: IDLE, ROUTE, DROP;
  - localparam helpers: clog2 function, default DW/N/SW.
- One natural sub-module: sel_out_reg, a single-entry valid/ready holding register with a load/drain interface and a registered destination index.
- The demux FSM and dest latch live in sel_demux_pkt.

Test Plan:
- Reset: hold RST_N=0 with IN_VALID=1 -> OUT_VALID=3'b000, BUSY=0, IN_READY=1; after release, first beat appears 1 cycle later.
- Single packet: SEL=2, beats 0xA1, 0xA2, 0xA3(last), OUT_READY=3'b111 -> OUT_VALID=3'b100 for 3 consecutive cycles with matching data; OUT_LAST on the third beat; BUSY high for 2 cycles.
- Mid-packet SEL change: SEL=1 on beat 0, SEL=0 on beats 1–2 -> all beats go to OUT_VALID=3'b010.
- Backpressure: OUT_READY[1]=0 for 4 cycles with a beat held -> IN_READY=0 and OUT_DATA stable; release -> drains next cycle and acceptance resumes.
- Back-to-back single-beat packets: SEL=0 then 1 then 2, all ready -> OUT_VALID sequence 001, 010, 100 on consecutive cycles, with no bubbles.
- Out of range, SEL=3 with 2 beats:
  - Macro defined: no OUT_VALID and one DROP pulse.
  - Macro undefined: beats appear on OUT_VALID=3'b100.
- Mid-packet reset: assert RST_N=0 during beat 2 of 4 -> outputs clear; next packet with SEL=0 routes to OUT_VALID=3'b001.
